ram_rmw_ctrl: RTL and testbench
===============================

Name: ram_rmw_ctrl

Overview:
- Requester-side controller for the pipelined single-port-write/single-port-read table RAM; drives the RAM write and read ports and consumes its delayed read data.
- Executes a stream of read-modify-write "add increment to entry" operations at one per cycle, with full forwarding so back-to-back updates to the same address are exact.
- Also sweeps the table to zero after reset or on request, because the RAM itself has no reset.
- Sits between hashmap update logic and the RAM instance.

Parameters:
ADDR_WIDTH, 4, table address width; 2**ADDR_WIDTH entries.
DATA_WIDTH, 8, entry width and increment width.
RAM_LATENCY, 1, cycles from RAM read address to read data; equals attached RAM read pipe depth + 1; minimum 1.
CLEAR_ON_RESET, 1, 1: sweep the table to zero after reset; 0: go straight to RUN.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  update request valid.
in_ready  out  1  request accepted when in_valid && in_ready.
in_addr  in  ADDR_WIDTH  entry to update.
in_inc  in  DATA_WIDTH  value added to entry.
clear_req  in  1  single-cycle pulse: zero the whole table.
busy  out  1  high while not in RUN.
out_valid  out  1  pulse: an update completed this cycle.
out_addr  out  ADDR_WIDTH  address of completed update.
out_val  out  DATA_WIDTH  new entry value written.
ram_write_en  out  1  RAM write enable.
ram_write_addr  out  ADDR_WIDTH  RAM write address.
ram_write_val  out  DATA_WIDTH  RAM write data.
ram_read_addr  out  ADDR_WIDTH  RAM read address.
ram_read_val  in  DATA_WIDTH  RAM read data, RAM_LATENCY cycles after address.

Behaviour:
- Reset: all outputs 0 except busy; pipeline and history valids cleared; FSM enters CLEAR (busy=1) if CLEAR_ON_RESET, else RUN (busy=0). RAM contents untouched by reset; any in-flight update is dropped.
- FSM: RUN, DRAIN, CLEAR. in_ready = (state==RUN), a function of state only.
- RUN: on clear_req go to DRAIN. A request accepted in the same cycle is still completed.
- DRAIN: no acceptance; wait until no update is in flight, then go to CLEAR with sweep counter = 0.
- CLEAR: each cycle write 0 to the counter address, then increment the counter. After the write to address 2**ADDR_WIDTH-1, go to RUN and flush write history. CLEAR lasts exactly 2**ADDR_WIDTH cycles. clear_req is ignored outside RUN.
- Issue: ram_read_addr = in_addr combinationally, so the read issues in the acceptance cycle t. {valid, addr, inc} enter a RAM_LATENCY-deep shift register.
- Writeback cycle t+RAM_LATENCY:
  - base = youngest matching-address entry in the write history, else ram_read_val.
  - new = (base + inc) mod 2**DATA_WIDTH; wraps silently, no saturation.
  - ram_write_en=1, ram_write_addr=addr, ram_write_val=new; out_valid=1, out_addr=addr, out_val=new, all in the same cycle.
- Write history: RAM_LATENCY entries {valid, addr, val}, holding the writes of the previous RAM_LATENCY cycles. Entry 1 is the previous cycle. These writes are not visible to the read, because the RAM is read-before-write and writes land after the read sampled.
- Latency: acceptance to out_valid is exactly RAM_LATENCY cycles. Throughput is 1 per cycle. There is no output backpressure.
- ram_write_en is 0 in RUN/DRAIN cycles with no writeback.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy high; ram_write_en high 16 cycles, addrs 0..15, val 0; then busy=0, in_ready=1.
- RAM_LATENCY=2; back-to-back addr 5 with inc 1,2,3 -> out_val 1,3,6 on consecutive cycles, 2 cycles after each accept; final RAM[5]=6.
- RAM_LATENCY=2; addrs 5,6,5 with inc 4,1,4 on consecutive cycles -> out_val 4,1,8, forwarding from history entry 2.
- RAM[3]=250, add 10 at DATA_WIDTH=8 -> out_val 4, ram_write_val 4.
- clear_req in the same cycle as an accepted update to addr 2 (inc 7) -> out_val 7 completes; DRAIN; 16-cycle zero sweep; a subsequent +1 to addr 2 returns 1.
- rst_n low for 1 cycle while 2 updates are in flight -> no out_valid for them; CLEAR sweep restarts from addr 0.

Source files
------------

// File: rtl/ram_rmw_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rmw_ctrl_if
//  Description : Request, completion, clear and RAM-port bundle for the
//                read-modify-write table controller.
//                slave  = the controller itself.
//                master = the requester plus the attached RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_rmw_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    // Update request stream
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_inc;

    // Table clear control and status
    logic                  clear_req;
    logic                  busy;

    // Completion stream
    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_val;

    // RAM write port, read address and returning read data
    logic                  ram_write_en;
    logic [ADDR_WIDTH-1:0] ram_write_addr;
    logic [DATA_WIDTH-1:0] ram_write_val;
    logic [ADDR_WIDTH-1:0] ram_read_addr;
    logic [DATA_WIDTH-1:0] ram_read_val;

    modport slave (
        input  in_valid, in_addr, in_inc, clear_req, ram_read_val,
        output in_ready, busy, out_valid, out_addr, out_val,
               ram_write_en, ram_write_addr, ram_write_val, ram_read_addr
    );

    modport master (
        output in_valid, in_addr, in_inc, clear_req, ram_read_val,
        input  in_ready, busy, out_valid, out_addr, out_val,
               ram_write_en, ram_write_addr, ram_write_val, ram_read_addr
    );
endinterface
`default_nettype wire

// File: rtl/ram_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rmw_ctrl
//  Description : One-per-cycle "entry += increment" read-modify-write engine
//                for a pipelined table RAM, with write-history forwarding so
//                back-to-back updates to one address are exact, and a
//                table-zeroing sweep after reset or on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_rmw_ctrl #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int RAM_LATENCY    = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_rmw_ctrl_if.slave bus
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;

    // Issue pipeline: stage 0 holds the request accepted last cycle, stage
    // RAM_LATENCY-1 is the one whose read data is on ram_read_val now.
    logic [RAM_LATENCY-1:0]                 pipe_valid_q, pipe_valid_d;
    logic [RAM_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_addr_q,  pipe_addr_d;
    logic [RAM_LATENCY-1:0][DATA_WIDTH-1:0] pipe_inc_q,   pipe_inc_d;

    // Write history: entry 0 is last cycle's write, entry RAM_LATENCY-1 the
    // oldest write the RAM read could still have missed.
    logic [RAM_LATENCY-1:0]                 hist_valid_q, hist_valid_d;
    logic [RAM_LATENCY-1:0][ADDR_WIDTH-1:0] hist_addr_q,  hist_addr_d;
    logic [RAM_LATENCY-1:0][DATA_WIDTH-1:0] hist_val_q,   hist_val_d;

    logic                  accept;
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_inc;
    logic [DATA_WIDTH-1:0] wb_base;
    logic [DATA_WIDTH-1:0] wb_val;
    logic                  we;
    logic [ADDR_WIDTH-1:0] we_addr;
    logic [DATA_WIDTH-1:0] we_val;
    logic                  sweep_done;

    assign accept     = bus.in_valid && (state_q == ST_RUN);
    assign wb_valid   = pipe_valid_q[RAM_LATENCY-1];
    assign wb_addr    = pipe_addr_q[RAM_LATENCY-1];
    assign wb_inc     = pipe_inc_q[RAM_LATENCY-1];
    assign sweep_done = (state_q == ST_CLEAR) && (sweep_q == LAST_ADDR);

    // Pick the freshest value of the writeback entry: walk oldest to youngest
    // so the most recent matching history write overrides the RAM data.
    always_comb begin
        wb_base = bus.ram_read_val;
        for (int i = RAM_LATENCY - 1; i >= 0; i--) begin
            if (hist_valid_q[i] && (hist_addr_q[i] == wb_addr)) begin
                wb_base = hist_val_q[i];
            end
        end
        wb_val = wb_base + wb_inc;
    end

    // RAM write port mux: sweep zeroes in CLEAR, otherwise the writeback.
    // The sweep write is held off while reset is asserted so the RAM is not
    // disturbed during reset.
    always_comb begin
        we      = 1'b0;
        we_addr = '0;
        we_val  = '0;
        if (state_q == ST_CLEAR) begin
            we      = rst_n;
            we_addr = sweep_q;
        end else if (wb_valid) begin
            we      = 1'b1;
            we_addr = wb_addr;
            we_val  = wb_val;
        end
    end

    // Next state of the controller FSM and sweep counter.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_valid_q == '0) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end
            end
            ST_CLEAR: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Next contents of the issue pipeline and the write history.
    always_comb begin
        pipe_valid_d   = pipe_valid_q;
        pipe_addr_d    = pipe_addr_q;
        pipe_inc_d     = pipe_inc_q;
        pipe_valid_d[0] = accept;
        pipe_addr_d[0]  = bus.in_addr;
        pipe_inc_d[0]   = bus.in_inc;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_addr_d[i]  = pipe_addr_q[i-1];
            pipe_inc_d[i]   = pipe_inc_q[i-1];
        end

        hist_valid_d   = hist_valid_q;
        hist_addr_d    = hist_addr_q;
        hist_val_d     = hist_val_q;
        hist_valid_d[0] = we;
        hist_addr_d[0]  = we_addr;
        hist_val_d[0]   = we_val;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            hist_valid_d[i] = hist_valid_q[i-1];
            hist_addr_d[i]  = hist_addr_q[i-1];
            hist_val_d[i]   = hist_val_q[i-1];
        end
        // The table is all zero after a sweep; nothing older may forward.
        if (sweep_done) begin
            hist_valid_d = '0;
        end
    end

    // State, counter, pipeline and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            sweep_q      <= '0;
            pipe_valid_q <= '0;
            pipe_addr_q  <= '0;
            pipe_inc_q   <= '0;
            hist_valid_q <= '0;
            hist_addr_q  <= '0;
            hist_val_q   <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_addr_q  <= pipe_addr_d;
            pipe_inc_q   <= pipe_inc_d;
            hist_valid_q <= hist_valid_d;
            hist_addr_q  <= hist_addr_d;
            hist_val_q   <= hist_val_d;
        end
    end

    assign bus.in_ready       = (state_q == ST_RUN);
    assign bus.busy           = (state_q != ST_RUN);
    assign bus.ram_read_addr  = bus.in_addr;
    assign bus.ram_write_en   = we;
    assign bus.ram_write_addr = we_addr;
    assign bus.ram_write_val  = we_val;
    assign bus.out_valid      = wb_valid;
    assign bus.out_addr       = wb_valid ? wb_addr : '0;
    assign bus.out_val        = wb_valid ? wb_val  : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_rmw_ctrl
//  Description : Self-checking bench for ram_rmw_ctrl with a behavioural RAM,
//                a vector table, directed corner sequences and a randomized
//                phase compared against a sequential table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rmw_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_rmw_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_rmw_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .RAM_LATENCY   (LAT),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Behavioural read-before-write RAM with LAT cycles of read latency.
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (bus.ram_write_en) mem[bus.ram_write_addr] <= bus.ram_write_val;
        rd_pipe[0] <= mem[bus.ram_read_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ram_read_val = rd_pipe[LAT-1];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Sequential model: each accepted update sees all earlier ones.
    typedef struct {
        int            due;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
    } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] inc;
        logic          ov;
        logic [AW-1:0] oa;
        logic [DW-1:0] oval;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] inc, input logic clr);
        bus.in_valid  = v;
        bus.in_addr   = a;
        bus.in_inc    = inc;
        bus.clear_req = clr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Compare the completion/write ports against the model queue (at negedge).
    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk({tag, " out_valid"}, bus.out_valid, 1);
            chk({tag, " out_addr"},  bus.out_addr, e.a);
            chk({tag, " out_val"},   bus.out_val, e.v);
            chk({tag, " we"},        bus.ram_write_en, 1);
            chk({tag, " waddr"},     bus.ram_write_addr, e.a);
            chk({tag, " wval"},      bus.ram_write_val, e.v);
        end else begin
            chk({tag, " out_valid idle"}, bus.out_valid, 0);
        end
    endtask

    // Full 16-cycle zero sweep from address 0, then RUN.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk({tag, " sweep we"},    bus.ram_write_en, 1);
            chk({tag, " sweep addr"},  bus.ram_write_addr, i);
            chk({tag, " sweep val"},   bus.ram_write_val, 0);
            chk({tag, " sweep busy"},  bus.busy, 1);
            chk({tag, " sweep ready"}, bus.in_ready, 0);
            chk({tag, " sweep ov"},    bus.out_valid, 0);
            next_cycle();
        end
        @(negedge clk);
        chk({tag, " post busy"},  bus.busy, 0);
        chk({tag, " post ready"}, bus.in_ready, 1);
        chk({tag, " post we"},    bus.ram_write_en, 0);
        next_cycle();
    endtask

    // One accepted update followed by its completion LAT cycles later.
    task automatic issue_expect(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] inc,
                                input logic [DW-1:0] expv);
        drive(1'b1, a, inc, 1'b0);
        @(negedge clk);
        chk({tag, " ready"}, bus.in_ready, 1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < LAT - 1; i++) begin
            @(negedge clk);
            chk({tag, " early ov"}, bus.out_valid, 0);
            next_cycle();
        end
        @(negedge clk);
        chk({tag, " ov"},   bus.out_valid, 1);
        chk({tag, " addr"}, bus.out_addr, a);
        chk({tag, " val"},  bus.out_val, expv);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          rv, rclr;
        logic [AW-1:0] ra;
        logic [DW-1:0] rinc, nv;
        int            k, seen, sidx;
        bit            done;

        // in: v a inc | expected same-cycle: ov oa oval   (LAT = 2)
        tbl[0]  = '{1'b1, 4'd5, 8'd1,   1'b0, 4'd0, 8'd0};
        tbl[1]  = '{1'b1, 4'd5, 8'd2,   1'b0, 4'd0, 8'd0};
        tbl[2]  = '{1'b1, 4'd5, 8'd3,   1'b1, 4'd5, 8'd1};
        tbl[3]  = '{1'b0, 4'd0, 8'd0,   1'b1, 4'd5, 8'd3};
        tbl[4]  = '{1'b0, 4'd0, 8'd0,   1'b1, 4'd5, 8'd6};
        tbl[5]  = '{1'b1, 4'd5, 8'd4,   1'b0, 4'd0, 8'd0};
        tbl[6]  = '{1'b1, 4'd6, 8'd1,   1'b0, 4'd0, 8'd0};
        tbl[7]  = '{1'b1, 4'd5, 8'd4,   1'b1, 4'd5, 8'd10};
        tbl[8]  = '{1'b0, 4'd0, 8'd0,   1'b1, 4'd6, 8'd1};
        tbl[9]  = '{1'b0, 4'd0, 8'd0,   1'b1, 4'd5, 8'd14};
        tbl[10] = '{1'b1, 4'd3, 8'd250, 1'b0, 4'd0, 8'd0};
        tbl[11] = '{1'b0, 4'd0, 8'd0,   1'b0, 4'd0, 8'd0};
        tbl[12] = '{1'b1, 4'd3, 8'd10,  1'b1, 4'd3, 8'd250};
        tbl[13] = '{1'b0, 4'd0, 8'd0,   1'b0, 4'd0, 8'd0};
        tbl[14] = '{1'b0, 4'd0, 8'd0,   1'b1, 4'd3, 8'd4};

        // ---------------- power-on reset and sweep ----------------
        drive(1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset busy",  bus.busy, 1);
        chk("reset ready", bus.in_ready, 0);
        chk("reset ov",    bus.out_valid, 0);
        chk("reset we",    bus.ram_write_en, 0);
        next_cycle();
        rst_n = 1'b1;
        check_sweep("por");

        // ---------------- vector table ----------------
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].inc, 1'b0);
            @(negedge clk);
            chk("tbl out_valid", bus.out_valid, tbl[i].ov);
            chk("tbl we",        bus.ram_write_en, tbl[i].ov);
            chk("tbl busy",      bus.busy, 0);
            chk("tbl raddr",     bus.ram_read_addr, tbl[i].a);
            if (tbl[i].ov) begin
                chk("tbl out_addr", bus.out_addr, tbl[i].oa);
                chk("tbl out_val",  bus.out_val, tbl[i].oval);
                chk("tbl waddr",    bus.ram_write_addr, tbl[i].oa);
                chk("tbl wval",     bus.ram_write_val, tbl[i].oval);
            end
            next_cycle();
        end
        chk("ram[5] final", mem[5], 14);
        chk("ram[3] wrap",  mem[3], 4);

        // ---------------- clear_req together with an update ----------------
        drive(1'b1, 4'd2, 8'd7, 1'b1);
        @(negedge clk);
        chk("clr ready", bus.in_ready, 1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("drain busy",  bus.busy, 1);
        chk("drain ready", bus.in_ready, 0);
        k = 0; seen = 0; sidx = 0; done = 1'b0;
        while (!done && k < 60) begin
            if (bus.out_valid) begin
                seen++;
                chk("clr upd addr", bus.out_addr, 2);
                chk("clr upd val",  bus.out_val, 7);
                chk("clr upd lat",  k, LAT - 1);
            end else if (bus.ram_write_en) begin
                chk("clr sweep addr", bus.ram_write_addr, sidx);
                chk("clr sweep val",  bus.ram_write_val, 0);
                sidx++;
            end
            if (!bus.busy) begin
                done = 1'b1;
            end else begin
                next_cycle();
                @(negedge clk);
                k++;
            end
        end
        chk("clr busy ends",   done, 1);
        chk("clr upd count",   seen, 1);
        chk("clr sweep count", sidx, DEPTH);
        next_cycle();
        issue_expect("post-clr", 4'd2, 8'd1, 8'd1);

        // ---------------- reset with two updates in flight ----------------
        drive(1'b1, 4'd4, 8'd3, 1'b0);
        next_cycle();
        drive(1'b1, 4'd7, 8'd5, 1'b0);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid-rst ov",   bus.out_valid, 0);
        chk("mid-rst we",   bus.ram_write_en, 0);
        chk("mid-rst busy", bus.busy, 1);
        next_cycle();
        rst_n = 1'b1;
        check_sweep("rst");

        // ---------------- randomized phase ----------------
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int n = 0; n < 600; n++) begin
            rv   = ($urandom_range(0, 9) < 8);
            ra   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                               : AW'($urandom_range(0, 2));
            rinc = DW'($urandom);
            rclr = ($urandom_range(0, 99) == 0);
            drive(rv, ra, rinc, rclr);
            @(negedge clk);
            check_out("rnd");
            if (rv && bus.in_ready) begin
                nv         = ref_mem[ra] + rinc;
                ref_mem[ra] = nv;
                exp_q.push_back('{cyc + LAT, ra, nv});
            end
            if (rclr && bus.in_ready) begin
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end
            next_cycle();
        end
        drive(1'b0, '0, '0, 1'b0);
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            check_out("rnd drain");
            if (exp_q.size() == 0 && !bus.busy) done = 1'b1;
            next_cycle();
        end
        chk("rnd drained", exp_q.size(), 0);
        next_cycle();
        for (int i = 0; i < DEPTH; i++) begin
            chk("rnd ram contents", mem[i], ref_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
